weight_reg_pingpong: RTL and testbench
======================================

Name: weight_reg_pingpong

Overview:
Parametrised double-buffered (ping-pong) weight register bank for the TLUT multiplier array. A narrow streaming loader fills a shadow bank, LOAD_LANES weights per beat, while the active bank drives all DIM_C channel weights to the datapath. On a swap request the shadow bank becomes active atomically, so the array never sees a partially updated weight set.

Parameters:
DIM_C, 16, number of weight channels presented to the array
WEIGHT_WIDTH, 8, bits per weight
LOAD_LANES, 4, weights accepted per load beat; DIM_C must be an integer multiple of LOAD_LANES
BEATS (derived), DIM_C/LOAD_LANES, beats per full weight set

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
in_valid  in  1  load beat valid
in_ready  out  1  shadow bank can accept a beat
in_data  in  LOAD_LANES x WEIGHT_WIDTH  packed weights of one beat
clear  in  1  synchronous flush of shadow bank and beat counter
swap_req  in  1  request to promote the shadow bank to active (level)
swap_ack  out  1  one-cycle pulse when the swap takes effect
shadow_full  out  1  shadow bank holds a complete set
active_valid  out  1  active bank holds a loaded set
out  out  DIM_C x WEIGHT_WIDTH  active weights, registered

Behaviour:
- Reset (async, rst_n low): both banks, out, beat counter, shadow_full, active_valid and swap_ack go to 0. in_ready = 1 once reset is released.
- State is FILLING (shadow_full=0) or FULL (shadow_full=1). in_ready = !shadow_full, combinational from state.
- Beat accept: occurs when in_valid && in_ready && !clear. Lane j of beat b is written to shadow channel b*LOAD_LANES+j. The beat counter increments, 0..BEATS-1.
- Accept of beat BEATS-1: the counter wraps to 0 and the state goes to FULL on the same edge.
- In FULL, in_ready=0 and no beats are accepted. in_data is ignored whenever no accept occurs.
- Swap: if swap_req && shadow_full && !clear at an edge, then on that edge:
  - active <= shadow, so out updates; latency is 1 cycle from the sampled swap_req.
  - shadow_full <= 0, active_valid <= 1, swap_ack = 1 for exactly that one following cycle.
- swap_req while FILLING is ignored. No ack is given and the request is not remembered; the consumer holds it level until ack.
- Last beat and swap_req in the same cycle: the beat is accepted and the state goes FULL. The swap is not taken that cycle. It is taken on the next edge if swap_req is still high.
- Swap and new loading: the shadow contents are not zeroed after a swap. A new load overwrites them beat by beat. in_ready returns to 1 the cycle after the swap edge.
- clear has priority over load and swap:
  - beat counter <= 0, shadow_full <= 0, no accept, no swap.
  - active bank, out and active_valid are unchanged.
- Reset asserted mid-load or mid-swap: everything returns to reset values immediately, with no partial state surviving.
- out changes only on a swap edge or on reset, never during loading.

Test Plan:
(DIM_C=4, WEIGHT_WIDTH=8, LOAD_LANES=2, BEATS=2)
- Reset then idle -> out=0, active_valid=0, shadow_full=0, in_ready=1, swap_ack=0.
- Load beats {0x11,0x22} then {0x33,0x44}, then swap_req -> shadow_full=1 after beat 2 and in_ready=0. One cycle after the swap edge: out = ch0..3 = 0x11,0x22,0x33,0x44, swap_ack pulses for one cycle, active_valid=1.
- With set A active, load {0xA0,0xA1},{0xA2,0xA3}, holding in_valid high with garbage for 3 extra cycles -> extra beats refused, out stays set A until swap, then becomes 0xA0..0xA3.
- swap_req asserted during beat 1 and held; last beat arrives with swap_req high -> no ack on the last-beat edge; ack and out update on the following edge.
- Load one beat {0x55,0x66}, pulse clear, then load {0x01,0x02},{0x03,0x04} and swap -> out=0x01..0x04 and active unchanged before the swap. Also: clear and swap_req in the same cycle while FULL -> no ack, shadow_full=0.
- Assert rst_n low asynchronously mid-load after one beat -> all outputs 0 immediately. After release a full 2-beat load is required before shadow_full=1.

Source files
------------

// File: rtl/weight_reg_pingpong.sv
// weight_reg_pingpong: double-buffered weight bank; a beat-wise loader fills the shadow
// bank while the active bank drives the array, and a swap promotes shadow to active atomically.
module weight_reg_pingpong #(
    parameter int DIM_C        = 16,
    parameter int WEIGHT_WIDTH = 8,
    parameter int LOAD_LANES   = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LOAD_LANES*WEIGHT_WIDTH-1:0] in_data,
    input  logic                            clear,
    input  logic                            swap_req,
    output logic                            swap_ack,
    output logic                            shadow_full,
    output logic                            active_valid,
    output logic [DIM_C*WEIGHT_WIDTH-1:0]   out
);
    localparam int BEATS = DIM_C / LOAD_LANES;
    localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int BW    = LOAD_LANES * WEIGHT_WIDTH;

    logic [DIM_C*WEIGHT_WIDTH-1:0] r_shadow;
    logic [DIM_C*WEIGHT_WIDTH-1:0] r_out;
    logic [CW-1:0]                 r_beat;
    logic                          r_full;
    logic                          r_active_valid;
    logic                          r_swap_ack;
    logic                          w_full_nxt;
    logic                          w_accept;
    logic                          w_swap;
    logic                          w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_full <= 1'b0;
        else
            r_full <= w_full_nxt;
    end

    // clear dominates; a last beat coinciding with swap_req only fills, the swap waits an edge
    always_comb begin
        w_full_nxt = r_full;
        if (clear || w_swap)
            w_full_nxt = 1'b0;
        else if (w_accept && w_last)
            w_full_nxt = 1'b1;
    end

    always_comb begin
        in_ready = !r_full;
        w_accept = in_valid && !r_full && !clear;
        w_swap   = swap_req && r_full && !clear;
        w_last   = r_beat == CW'(BEATS - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat         <= '0;
            r_out          <= '0;
            r_active_valid <= 1'b0;
            r_swap_ack     <= 1'b0;
        end else begin
            r_swap_ack <= w_swap;
            if (clear)
                r_beat <= '0;
            else if (w_accept)
                r_beat <= w_last ? '0 : r_beat + 1'b1;
            if (w_swap) begin
                r_out          <= r_shadow;
                r_active_valid <= 1'b1;
            end
        end
    end

    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_shadow[b*BW +: BW] <= '0;
            else if (w_accept && r_beat == CW'(b))
                r_shadow[b*BW +: BW] <= in_data;
        end
    end

    assign swap_ack     = r_swap_ack;
    assign shadow_full  = r_full;
    assign active_valid = r_active_valid;
    assign out          = r_out;
endmodule

// File: tb/tb_weight_reg_pingpong.sv
// tb_weight_reg_pingpong: directed scenarios plus a randomized run, all checked against
// a cycle-level behavioural model of the ping-pong bank.
module tb_weight_reg_pingpong;
    localparam int C = 4, W = 8, L = 2, BEATS = C / L;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [L*W-1:0] in_data = '0;
    logic           clear = 1'b0;
    logic           swap_req = 1'b0;
    logic           swap_ack;
    logic           shadow_full;
    logic           active_valid;
    logic [C*W-1:0] out;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [W-1:0] m_sh[C];
    logic [W-1:0] m_act[C];
    int           m_beat;
    bit           m_full, m_av, m_ack;

    wire [3:0] st = {in_ready, shadow_full, active_valid, swap_ack};

    weight_reg_pingpong #(.DIM_C(C), .WEIGHT_WIDTH(W), .LOAD_LANES(L)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .clear(clear), .swap_req(swap_req), .swap_ack(swap_ack),
        .shadow_full(shadow_full), .active_valid(active_valid), .out(out)
    );

    always #5 clk = ~clk;

    function automatic logic [C*W-1:0] m_out();
        logic [C*W-1:0] v;
        for (int c = 0; c < C; c++) v[c*W +: W] = m_act[c];
        return v;
    endfunction

    function automatic logic [3:0] m_st();
        return {!m_full, m_full, m_av, m_ack};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < C; c++) begin
            m_sh[c] = '0;
            m_act[c] = '0;
        end
        m_beat = 0;
        m_full = 0;
        m_av = 0;
        m_ack = 0;
    endtask

    task automatic model_step();
        m_ack = 0;
        if (clear) begin
            m_beat = 0;
            m_full = 0;
        end else if (m_full && swap_req) begin
            for (int c = 0; c < C; c++) m_act[c] = m_sh[c];
            m_full = 0;
            m_av = 1;
            m_ack = 1;
        end else if (!m_full && in_valid) begin
            for (int j = 0; j < L; j++) m_sh[m_beat*L + j] = in_data[j*W +: W];
            m_beat++;
            if (m_beat == BEATS) begin
                m_beat = 0;
                m_full = 1;
            end
        end
    endtask

    task automatic drive(input logic v, input logic [L*W-1:0] d, input logic clr, input logic sw);
        in_valid = v;
        in_data = d;
        clear = clr;
        swap_req = sw;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #12 rst_n = 1'b1;
        tick();
        total_cnt++;
        if (out !== '0) $display("FAIL reset_out got %h exp 0", out); else pass_cnt++;
        total_cnt++;
        if (st !== 4'b1000) $display("FAIL reset_status got %b exp 1000", st); else pass_cnt++;
    endtask

    task automatic test_basic_load();
        drive(1, 16'h2211, 0, 0); tick();
        total_cnt++;
        if (st !== 4'b1000) $display("FAIL basic_beat1 status got %b exp 1000", st); else pass_cnt++;
        drive(1, 16'h4433, 0, 0); tick();
        total_cnt++;
        if (st !== 4'b0100) $display("FAIL basic_full status got %b exp 0100", st); else pass_cnt++;
        total_cnt++;
        if (out !== '0) $display("FAIL basic_out_before_swap got %h exp 0", out); else pass_cnt++;
        drive(0, 0, 0, 1); tick();
        total_cnt++;
        if (out !== 32'h44332211) $display("FAIL basic_swap_out got %h exp 44332211", out); else pass_cnt++;
        total_cnt++;
        if (st !== 4'b1011) $display("FAIL basic_swap_status got %b exp 1011", st); else pass_cnt++;
        drive(0, 0, 0, 0); tick();
        total_cnt++;
        if (st !== 4'b1010) $display("FAIL basic_ack_one_cycle got %b exp 1010", st); else pass_cnt++;
    endtask

    task automatic test_overflow();
        drive(1, 16'hA1A0, 0, 0); tick();
        drive(1, 16'hA3A2, 0, 0); tick();
        total_cnt++;
        if (st !== 4'b0110) $display("FAIL ovf_full status got %b exp 0110", st); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            drive(1, 16'($urandom), 0, 0); tick();
            total_cnt++;
            if (out !== 32'h44332211 || st !== 4'b0110)
                $display("FAIL ovf_refuse%0d got out=%h st=%b exp out=44332211 st=0110", i, out, st);
            else pass_cnt++;
        end
        drive(0, 0, 0, 1); tick();
        total_cnt++;
        if (out !== 32'hA3A2A1A0 || st !== 4'b1011)
            $display("FAIL ovf_swap got out=%h st=%b exp out=a3a2a1a0 st=1011", out, st);
        else pass_cnt++;
        drive(0, 0, 0, 0); tick();
    endtask

    task automatic test_swap_during_load();
        drive(1, 16'($urandom), 0, 1); tick();
        total_cnt++;
        if (st !== 4'b1010) $display("FAIL sdl_beat1 got %b exp 1010", st); else pass_cnt++;
        drive(1, 16'($urandom), 0, 1); tick();
        total_cnt++;
        if (st !== 4'b0110 || out !== 32'hA3A2A1A0)
            $display("FAIL sdl_last_beat_no_ack got st=%b out=%h exp st=0110 out=a3a2a1a0", st, out);
        else pass_cnt++;
        drive(0, 0, 0, 1); tick();
        total_cnt++;
        if (st !== 4'b1011 || out !== m_out())
            $display("FAIL sdl_swap got st=%b out=%h exp st=1011 out=%h", st, out, m_out());
        else pass_cnt++;
        drive(0, 0, 0, 0); tick();
    endtask

    task automatic test_clear();
        logic [C*W-1:0] prev;
        prev = m_out();
        drive(1, 16'h6655, 0, 0); tick();
        drive(0, 0, 1, 0); tick();
        total_cnt++;
        if (st !== 4'b1010 || out !== prev)
            $display("FAIL clr_flush got st=%b out=%h exp st=1010 out=%h", st, out, prev);
        else pass_cnt++;
        drive(1, 16'h0201, 0, 0); tick();
        total_cnt++;
        if (st !== 4'b1010) $display("FAIL clr_counter_restart got %b exp 1010", st); else pass_cnt++;
        drive(1, 16'h0403, 0, 0); tick();
        total_cnt++;
        if (st !== 4'b0110 || out !== prev)
            $display("FAIL clr_reload got st=%b out=%h exp st=0110 out=%h", st, out, prev);
        else pass_cnt++;
        drive(0, 0, 0, 1); tick();
        total_cnt++;
        if (out !== 32'h04030201) $display("FAIL clr_swap_out got %h exp 04030201", out); else pass_cnt++;
        drive(1, 16'h1111, 0, 0); tick();
        drive(1, 16'h2222, 0, 0); tick();
        drive(0, 0, 1, 1); tick();
        total_cnt++;
        if (st !== 4'b1010 || out !== 32'h04030201)
            $display("FAIL clr_beats_swap got st=%b out=%h exp st=1010 out=04030201", st, out);
        else pass_cnt++;
        drive(1, 16'h3333, 0, 1); tick();
        total_cnt++;
        if (st !== 4'b1010) $display("FAIL clr_after_swap_partial got %b exp 1010", st); else pass_cnt++;
        drive(0, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        total_cnt++;
        if (out !== '0 || st !== 4'b1000)
            $display("FAIL arst_immediate got out=%h st=%b exp out=0 st=1000", out, st);
        else pass_cnt++;
        #7 rst_n = 1'b1;
        drive(1, 16'h7777, 0, 0); tick();
        total_cnt++;
        if (st !== 4'b1000) $display("FAIL arst_beat1_not_full got %b exp 1000", st); else pass_cnt++;
        drive(1, 16'h8888, 0, 0); tick();
        total_cnt++;
        if (st !== 4'b0100) $display("FAIL arst_beat2_full got %b exp 0100", st); else pass_cnt++;
        drive(0, 0, 0, 1); tick();
        total_cnt++;
        if (out !== 32'h88887777) $display("FAIL arst_swap_out got %h exp 88887777", out); else pass_cnt++;
        drive(0, 0, 0, 0); tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, 16'($urandom), ($urandom % 16) == 0, ($urandom % 3) == 0);
            tick();
            total_cnt++;
            if (out !== m_out() || st !== m_st())
                $display("FAIL rand%0d got out=%h st=%b exp out=%h st=%b", i, out, st, m_out(), m_st());
            else pass_cnt++;
        end
        drive(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_overflow();
        test_swap_during_load();
        test_clear();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
